// File: rtl/alu_pkg.sv
// Shared types, widths and the ALU function for the result sequencer
// and the 7-segment display stage.
package alu_pkg;

    localparam int OPW  = 5;
    localparam int RESW = OPW + 1;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_RSV2 = 3'b010,
        OP_RSV3 = 3'b011,
        OP_EQ   = 3'b100,
        OP_LT   = 3'b101,
        OP_GT   = 3'b110,
        OP_NE   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        EXEC   = 2'b10,
        SHOW   = 2'b11
    } seq_state_e;

    function automatic logic op_invalid(input alu_op_e op);
        return (op == OP_RSV2) || (op == OP_RSV3);
    endfunction

    // Operands are widened by one bit first, so ADD/SUB cannot overflow.
    function automatic logic [RESW-1:0] alu_exec(
        input alu_op_e               op,
        input logic signed [OPW-1:0] a,
        input logic signed [OPW-1:0] b
    );
        logic signed [RESW-1:0] ea;
        logic signed [RESW-1:0] eb;
        logic        [RESW-1:0] r;
        ea = {a[OPW-1], a};
        eb = {b[OPW-1], b};
        case (op)
            OP_ADD:  r = ea + eb;
            OP_SUB:  r = ea - eb;
            OP_EQ:   r = {{(RESW-1){1'b0}}, ea == eb};
            OP_LT:   r = {{(RESW-1){1'b0}}, ea < eb};
            OP_GT:   r = {{(RESW-1){1'b0}}, ea > eb};
            OP_NE:   r = {{(RESW-1){1'b0}}, ea != eb};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_btn_conditioner.sv
// Push-button conditioner: 2-flop sync,
// optional debounce, one-cycle press pulse.
module btn_conditioner #(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic pulse
);

  logic s1;
  logic s2;
  logic lvl;
  logic lvl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ~btn_n;
      s2 <= s1;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int unsigned CW =
    $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      lvl <= 1'b0;
    end else if (s2 == lvl) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      cnt <= '0;
      lvl <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign lvl = s2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= 1'b0;
    else        lvl_q <= lvl;
  end

  assign pulse = lvl & ~lvl_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Two-press operand/opcode capture and
// single ALU execution for the display stage.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OPW-1:0]  sw_opnd,
  input  logic [2:0]      sw_instr,
  input  logic            btn_go_n,
  input  logic            btn_clr_n,
  output logic [RESW-1:0] C,
  output logic [2:0]      instr,
  output logic            res_valid,
  output logic            op_err,
  output logic [1:0]      state_led
);

  logic go_p;
  logic clr_p;

  btn_conditioner #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_go (
    .clk(clk), .rst_n(rst_n),
    .btn_n(btn_go_n), .pulse(go_p)
  );

  btn_conditioner #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_clr (
    .clk(clk), .rst_n(rst_n),
    .btn_n(btn_clr_n), .pulse(clr_p)
  );

  seq_state_e     state;
  seq_state_e     state_nx;
  logic [OPW-1:0] a_q;
  logic [OPW-1:0] b_q;
  alu_op_e        op_q;
  logic           ld_a;
  logic           ld_b;
  logic           do_exec;
  logic           drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clr_p) begin
      state_nx = LOAD_A;
    end else begin
      case (state)
        LOAD_A: if (go_p) state_nx = LOAD_B;
        LOAD_B: if (go_p) state_nx = EXEC;
        EXEC:   state_nx = SHOW;
        SHOW:   if (go_p) state_nx = LOAD_B;
        default: state_nx = LOAD_A;
      endcase
    end
  end

  always_comb begin
    ld_a    = !clr_p && go_p &&
              (state == LOAD_A ||
               state == SHOW);
    ld_b    = !clr_p && go_p &&
              (state == LOAD_B);
    do_exec = !clr_p && (state == EXEC);
    drop    = clr_p ||
              (go_p && state == SHOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else begin
      if (ld_a) a_q <= sw_opnd;
      if (ld_b) begin
        b_q  <= sw_opnd;
        op_q <= alu_op_e'(sw_instr);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      C         <= '0;
      instr     <= 3'b000;
      res_valid <= 1'b0;
      op_err    <= 1'b0;
    end else if (do_exec) begin
      C         <= alu_exec(op_q, a_q, b_q);
      instr     <= op_q;
      res_valid <= 1'b1;
      op_err    <= op_invalid(op_q);
    end else if (drop) begin
      res_valid <= 1'b0;
      op_err    <= 1'b0;
    end
  end

  assign state_led = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer;
// bounce scenario runs with ALU_SEQ_DEBOUNCE_EN.
module tb_alu_op_sequencer;

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int HOLD   = 6;
  localparam int SETTLE = 14;
`else
  localparam int HOLD   = 2;
  localparam int SETTLE = 6;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sw_opnd;
  logic [2:0] sw_instr;
  logic       btn_go_n;
  logic       btn_clr_n;
  logic [5:0] C;
  logic [2:0] instr;
  logic       res_valid;
  logic       op_err;
  logic [1:0] state_led;

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] m_c;
  logic [2:0] m_instr;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .DEB_CYCLES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .sw_opnd(sw_opnd), .sw_instr(sw_instr),
    .btn_go_n(btn_go_n), .btn_clr_n(btn_clr_n),
    .C(C), .instr(instr), .res_valid(res_valid),
    .op_err(op_err), .state_led(state_led)
  );

  function automatic void model(
    input int a, input int b, input int op,
    output logic [5:0] c, output logic e
  );
    int r;
    e = 1'b0;
    case (op)
      0: r = a + b;
      1: r = a - b;
      4: r = (a == b) ? 1 : 0;
      5: r = (a < b) ? 1 : 0;
      6: r = (a > b) ? 1 : 0;
      7: r = (a != b) ? 1 : 0;
      default: begin r = 0; e = 1'b1; end
    endcase
    c = r[5:0];
  endfunction

  task automatic press(
    input logic go, input logic clr,
    input int hold
  );
    @(negedge clk);
    btn_go_n  = ~go;
    btn_clr_n = ~clr;
    repeat (hold) @(negedge clk);
    btn_go_n  = 1'b1;
    btn_clr_n = 1'b1;
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic go_exec();
    bit found = 0;
    @(negedge clk);
    btn_go_n = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (i == HOLD - 1) btn_go_n = 1'b1;
      if (state_led == 2'b10) found = 1;
    end
    btn_go_n = 1'b1;
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL exec_timeout state_led=%b required=10",
               state_led);
    end else begin
      vectors++;
      if (res_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL exec_early res_valid=%b required=0",
                 res_valid);
      end
      @(negedge clk);
      vectors++;
      if (res_valid !== 1'b1 || state_led !== 2'b11) begin
        miscompares++;
        $display("FAIL exec_latency res_valid=%b state=%b required=1/11",
                 res_valid, state_led);
      end
    end
    repeat (SETTLE) @(negedge clk);
  endtask

  task automatic run_op(
    input int a, input int b, input int op,
    input string tag
  );
    logic [5:0] ec;
    logic       ee;
    sw_opnd = a[4:0];
    press(1'b1, 1'b0, HOLD);
    vectors++;
    if (state_led !== 2'b01 || res_valid !== 1'b0 ||
        C !== m_c) begin
      miscompares++;
      $display("FAIL %s_load_a state=%b valid=%b C=%b required=01/0/%b",
               tag, state_led, res_valid, C, m_c);
    end
    sw_opnd  = b[4:0];
    sw_instr = op[2:0];
    go_exec();
    model(a, b, op, ec, ee);
    m_c     = ec;
    m_instr = op[2:0];
    vectors++;
    if (C !== ec || instr !== m_instr ||
        op_err !== ee || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s a=%0d b=%0d op=%0d C=%b instr=%b err=%b valid=%b required C=%b instr=%b err=%b valid=1",
               tag, a, b, op, C, instr, op_err,
               res_valid, ec, m_instr, ee);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (C !== 6'd0 || instr !== 3'b000 ||
        res_valid !== 1'b0 || op_err !== 1'b0 ||
        state_led !== 2'b00) begin
      miscompares++;
      $display("FAIL reset C=%b instr=%b valid=%b err=%b state=%b required 0/000/0/0/00",
               C, instr, res_valid, op_err, state_led);
    end
    rst_n = 1'b1;
    m_c = '0;
    m_instr = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add();
    run_op(7, -9, 0, "add");
    vectors++;
    if (C !== 6'b111110) begin
      miscompares++;
      $display("FAIL add_const C=%b required=111110", C);
    end
  endtask

  task automatic test_compare();
    run_op(-16, 15, 5, "lt");
    vectors++;
    if (C !== 6'b000001) begin
      miscompares++;
      $display("FAIL lt_const C=%b required=000001", C);
    end
    run_op(-16, 15, 6, "gt");
    vectors++;
    if (C !== 6'b000000) begin
      miscompares++;
      $display("FAIL gt_const C=%b required=000000", C);
    end
  endtask

  task automatic test_invalid();
    run_op(3, 4, 3, "inv");
    vectors++;
    if (C !== 6'd0 || instr !== 3'b011 ||
        op_err !== 1'b1 || res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL inv_const C=%b instr=%b err=%b valid=%b required 0/011/1/1",
               C, instr, op_err, res_valid);
    end
  endtask

  task automatic test_clear();
    press(1'b0, 1'b1, HOLD);
    vectors++;
    if (state_led !== 2'b00 || res_valid !== 1'b0 ||
        op_err !== 1'b0 || C !== m_c ||
        instr !== m_instr) begin
      miscompares++;
      $display("FAIL clr_show state=%b valid=%b err=%b C=%b instr=%b required 00/0/0/%b/%b",
               state_led, res_valid, op_err, C, instr,
               m_c, m_instr);
    end
    sw_opnd = 5'd5;
    press(1'b1, 1'b0, HOLD);
    sw_opnd = 5'd9;
    press(1'b1, 1'b1, HOLD);
    vectors++;
    if (state_led !== 2'b00 || res_valid !== 1'b0 ||
        C !== m_c) begin
      miscompares++;
      $display("FAIL clr_wins state=%b valid=%b C=%b required 00/0/%b",
               state_led, res_valid, C, m_c);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int a  = int'($urandom_range(0, 31)) - 16;
      int b  = int'($urandom_range(0, 31)) - 16;
      int op = int'($urandom_range(0, 7));
      if (i % 5 == 2) b = a;
      run_op(a, b, op, "rand");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (C !== 6'd0 || instr !== 3'b000 ||
        res_valid !== 1'b0 || state_led !== 2'b00) begin
      miscompares++;
      $display("FAIL async_reset C=%b instr=%b valid=%b state=%b required 0/000/0/00",
               C, instr, res_valid, state_led);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_c = '0;
    m_instr = '0;
    repeat (2) @(negedge clk);
  endtask

`ifdef ALU_SEQ_DEBOUNCE_EN
  task automatic test_bounce();
    for (int g = 0; g < 3; g++) begin
      @(negedge clk);
      btn_go_n = 1'b0;
      repeat (3) @(negedge clk);
      btn_go_n = 1'b1;
      repeat (8) @(negedge clk);
    end
    vectors++;
    if (state_led !== 2'b00) begin
      miscompares++;
      $display("FAIL bounce_glitch state=%b required=00",
               state_led);
    end
    sw_opnd = 5'd1;
    press(1'b1, 1'b0, 6);
    vectors++;
    if (state_led !== 2'b01) begin
      miscompares++;
      $display("FAIL bounce_press state=%b required=01",
               state_led);
    end
    press(1'b0, 1'b1, 6);
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    sw_opnd   = '0;
    sw_instr  = '0;
    btn_go_n  = 1'b1;
    btn_clr_n = 1'b1;
    m_c       = '0;
    m_instr   = '0;
    test_reset();
`ifdef ALU_SEQ_DEBOUNCE_EN
    test_bounce();
`endif
    test_add();
    test_compare();
    test_invalid();
    test_clear();
    test_random();
    test_reset_mid();
    test_add();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
